// File: rtl/tl_fc_pkg.sv
// Shared flow-control definitions for the transaction-layer credit blocks:
// credit type codes, default field widths and the TX FC state encoding.
package tl_fc_pkg;

    localparam int HDR_FIELD_SIZE_DEF  = 8;
    localparam int DATA_FIELD_SIZE_DEF = 12;

    typedef enum logic [1:0] {
        POSTED     = 2'b00,
        NON_POSTED = 2'b01,
        COMPLETION = 2'b10,
        FC_NONE    = 2'b11
    } fc_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_INIT   = 2'b01,
        ST_ACTIVE = 2'b10
    } fc_state_e;

endpackage

// File: rtl/tl_tx_fc_type_ctr.sv
// Per-type TX credit tracker: CREDIT_LIMIT, CREDITS_CONSUMED, infinite flags
// and the modulo sufficiency test for one pending TLP of this type.
module tl_tx_fc_type_ctr
    import tl_fc_pkg::*;
#(
    parameter int HDR_W  = HDR_FIELD_SIZE_DEF,
    parameter int DATA_W = DATA_FIELD_SIZE_DEF
) (
    input  logic              i_clk,
    input  logic              i_n_rst,
    input  logic              i_clear,
    input  logic              i_init_wr,
    input  logic              i_upd_wr,
    input  logic [HDR_W-1:0]  i_hdr_field,
    input  logic [DATA_W-1:0] i_data_field,
    input  logic              i_debit,
    input  logic [DATA_W-1:0] i_req_data,
    output logic [HDR_W-1:0]  o_hdr_limit,
    output logic [DATA_W-1:0] o_data_limit,
    output logic [HDR_W-1:0]  o_hdr_consumed,
    output logic [DATA_W-1:0] o_data_consumed,
    output logic              o_pass
);

    localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [HDR_W-1:0]  HDR_ONE   = {{(HDR_W-1){1'b0}}, 1'b1};

    logic [HDR_W-1:0]  hdr_limit_q, hdr_limit_d, hdr_cons_q, hdr_cons_d;
    logic [DATA_W-1:0] data_limit_q, data_limit_d, data_cons_q, data_cons_d;
    logic              hdr_inf_q, hdr_inf_d, data_inf_q, data_inf_d;
    logic [HDR_W-1:0]  hdr_room;
    logic [DATA_W-1:0] data_room;

    always_comb begin
        hdr_limit_d  = hdr_limit_q;
        data_limit_d = data_limit_q;
        hdr_cons_d   = hdr_cons_q;
        data_cons_d  = data_cons_q;
        hdr_inf_d    = hdr_inf_q;
        data_inf_d   = data_inf_q;
        if (i_clear) begin
            hdr_limit_d  = '0;
            data_limit_d = '0;
            hdr_cons_d   = '0;
            data_cons_d  = '0;
            hdr_inf_d    = 1'b0;
            data_inf_d   = 1'b0;
        end else begin
            // A zero InitFC field means unlimited credit for that field
            if (i_init_wr) begin
                hdr_limit_d  = i_hdr_field;
                data_limit_d = i_data_field;
                hdr_inf_d    = (i_hdr_field == '0);
                data_inf_d   = (i_data_field == '0);
            end else if (i_upd_wr) begin
                if (!hdr_inf_q)  hdr_limit_d  = i_hdr_field;
                if (!data_inf_q) data_limit_d = i_data_field;
            end
            if (i_debit) begin
                hdr_cons_d = hdr_cons_q + HDR_ONE;
                if (!data_inf_q) data_cons_d = data_cons_q + i_req_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            hdr_limit_q  <= '0;
            data_limit_q <= '0;
            hdr_cons_q   <= '0;
            data_cons_q  <= '0;
            hdr_inf_q    <= 1'b0;
            data_inf_q   <= 1'b0;
        end else begin
            hdr_limit_q  <= hdr_limit_d;
            data_limit_q <= data_limit_d;
            hdr_cons_q   <= hdr_cons_d;
            data_cons_q  <= data_cons_d;
            hdr_inf_q    <= hdr_inf_d;
            data_inf_q   <= data_inf_d;
        end
    end

    // Remaining room after this TLP; wraps past half the range mean "short"
    assign hdr_room  = hdr_limit_q - hdr_cons_q - HDR_ONE;
    assign data_room = data_limit_q - data_cons_q - i_req_data;
    assign o_pass    = (hdr_inf_q || (hdr_room <= HDR_HALF)) &&
                       ((i_req_data == '0) || data_inf_q || (data_room <= DATA_HALF));

    assign o_hdr_limit     = hdr_limit_q;
    assign o_data_limit    = data_limit_q;
    assign o_hdr_consumed  = hdr_cons_q;
    assign o_data_consumed = data_cons_q;

endmodule

// File: rtl/tl_tx_fc.sv
// TX flow-control credit gate: FC init/active FSM, FC DLLP type decode and
// the registered TLP grant, over three per-type credit trackers.
module tl_tx_fc
    import tl_fc_pkg::*;
#(
    parameter int HDR_FIELD_SIZE  = HDR_FIELD_SIZE_DEF,
    parameter int DATA_FIELD_SIZE = DATA_FIELD_SIZE_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_n_rst,
    input  logic                         i_dll_ctrl_fc_init,
    input  logic                         i_dll_rx_fc_creds_valid,
    input  logic [1:0]                   i_dll_rx_fc_type,
    input  logic [HDR_FIELD_SIZE-1:0]    i_dll_rx_fc_hdr_creds,
    input  logic [DATA_FIELD_SIZE-1:0]   i_dll_rx_fc_data_creds,
    input  logic                         i_tlp_req_valid,
    input  logic [1:0]                   i_tlp_req_type,
    input  logic [DATA_FIELD_SIZE-1:0]   i_tlp_req_data_creds,
    output logic                         o_tlp_grant,
    output logic                         o_fc_init_done,
    output logic [3*HDR_FIELD_SIZE-1:0]  o_tx_fc_hdr_limit_bus,
    output logic [3*DATA_FIELD_SIZE-1:0] o_tx_fc_data_limit_bus,
    output logic [3*HDR_FIELD_SIZE-1:0]  o_tx_fc_hdr_consumed_bus,
    output logic [3*DATA_FIELD_SIZE-1:0] o_tx_fc_data_consumed_bus
);

    fc_state_e  state_q, state_d;
    logic [2:0] rcvd_q, rcvd_d;
    logic       grant_q, grant_d;
    logic       init_done_q, init_done_d;
    logic [2:0] fc_hit, init_wr, upd_wr, debit;
    logic [3:0] pass;
    logic       clear;

    assign clear   = (state_q == ST_ACTIVE) && i_dll_ctrl_fc_init;
    assign pass[3] = 1'b0;  // type 11 never passes

    for (genvar g = 0; g < 3; g++) begin : g_type
        assign fc_hit[g]  = i_dll_rx_fc_creds_valid && (i_dll_rx_fc_type == 2'(g));
        assign init_wr[g] = (state_q == ST_INIT) && fc_hit[g];
        assign upd_wr[g]  = (state_q == ST_ACTIVE) && !i_dll_ctrl_fc_init && fc_hit[g];
        assign debit[g]   = grant_d && (i_tlp_req_type == 2'(g));

        // Type 0 (P) sits in the most significant slice of each bus
        tl_tx_fc_type_ctr #(
            .HDR_W  (HDR_FIELD_SIZE),
            .DATA_W (DATA_FIELD_SIZE)
        ) u_ctr (
            .i_clk           (i_clk),
            .i_n_rst         (i_n_rst),
            .i_clear         (clear),
            .i_init_wr       (init_wr[g]),
            .i_upd_wr        (upd_wr[g]),
            .i_hdr_field     (i_dll_rx_fc_hdr_creds),
            .i_data_field    (i_dll_rx_fc_data_creds),
            .i_debit         (debit[g]),
            .i_req_data      (i_tlp_req_data_creds),
            .o_hdr_limit     (o_tx_fc_hdr_limit_bus[(2-g)*HDR_FIELD_SIZE +: HDR_FIELD_SIZE]),
            .o_data_limit    (o_tx_fc_data_limit_bus[(2-g)*DATA_FIELD_SIZE +: DATA_FIELD_SIZE]),
            .o_hdr_consumed  (o_tx_fc_hdr_consumed_bus[(2-g)*HDR_FIELD_SIZE +: HDR_FIELD_SIZE]),
            .o_data_consumed (o_tx_fc_data_consumed_bus[(2-g)*DATA_FIELD_SIZE +: DATA_FIELD_SIZE]),
            .o_pass          (pass[g])
        );
    end

    always_comb begin
        state_d = state_q;
        rcvd_d  = rcvd_q;
        grant_d = 1'b0;
        case (state_q)
            ST_IDLE: if (i_dll_ctrl_fc_init) state_d = ST_INIT;
            ST_INIT: begin
                rcvd_d = rcvd_q | fc_hit;
                if (&rcvd_q && !i_dll_ctrl_fc_init) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (i_dll_ctrl_fc_init) begin
                    state_d = ST_INIT;
                    rcvd_d  = '0;
                end else begin
                    // grant_q blocks back-to-back grants on a still-held request
                    grant_d = i_tlp_req_valid && !grant_q && pass[i_tlp_req_type];
                end
            end
            default: state_d = ST_IDLE;
        endcase
        init_done_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state_q     <= ST_IDLE;
            rcvd_q      <= '0;
            grant_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rcvd_q      <= rcvd_d;
            grant_q     <= grant_d;
            init_done_q <= init_done_d;
        end
    end

    assign o_tlp_grant    = grant_q;
    assign o_fc_init_done = init_done_q;

endmodule

// File: tb/tb_tl_tx_fc.sv
// Directed + randomized bench for tl_tx_fc against a credit-accounting model.
module tb_tl_tx_fc;

    localparam int HW = 8;
    localparam int DW = 12;
    localparam int MH = 256;
    localparam int MD = 4096;

    logic          clk, rst_n;
    logic          fc_init, fv;
    logic [1:0]    ft;
    logic [HW-1:0] fh;
    logic [DW-1:0] fd;
    logic          rq;
    logic [1:0]    rt;
    logic [DW-1:0] rd;
    logic          grant, init_done;
    logic [3*HW-1:0] hlim_bus, hcon_bus;
    logic [3*DW-1:0] dlim_bus, dcon_bus;

    tl_tx_fc dut (
        .i_clk                     (clk),
        .i_n_rst                   (rst_n),
        .i_dll_ctrl_fc_init        (fc_init),
        .i_dll_rx_fc_creds_valid   (fv),
        .i_dll_rx_fc_type          (ft),
        .i_dll_rx_fc_hdr_creds     (fh),
        .i_dll_rx_fc_data_creds    (fd),
        .i_tlp_req_valid           (rq),
        .i_tlp_req_type            (rt),
        .i_tlp_req_data_creds      (rd),
        .o_tlp_grant               (grant),
        .o_fc_init_done            (init_done),
        .o_tx_fc_hdr_limit_bus     (hlim_bus),
        .o_tx_fc_data_limit_bus    (dlim_bus),
        .o_tx_fc_hdr_consumed_bus  (hcon_bus),
        .o_tx_fc_data_consumed_bus (dcon_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: phase 0 idle, 1 init, 2 active
    int phase;
    bit m_grant;
    int lh[3], ld[3], ch[3], cd[3];
    bit ih[3], id[3], rv[3];

    function automatic bit fits(int lim, int con, int need, int m);
        int r;
        r = ((lim - con - need) % m + m) % m;
        return r <= m / 2;
    endfunction

    task automatic model_reset();
        phase = 0;
        m_grant = 0;
        for (int t = 0; t < 3; t++) begin
            lh[t] = 0; ld[t] = 0; ch[t] = 0; cd[t] = 0;
            ih[t] = 0; id[t] = 0; rv[t] = 0;
        end
    endtask

    task automatic model_edge();
        bit all_rcvd, g;
        int t, r;
        t = int'(ft);
        r = int'(rt);
        if (phase == 0) begin
            m_grant = 0;
            if (fc_init) phase = 1;
        end else if (phase == 1) begin
            m_grant = 0;
            all_rcvd = rv[0] && rv[1] && rv[2];
            if (fv && t < 3) begin
                lh[t] = int'(fh); ld[t] = int'(fd);
                ih[t] = (fh == 0); id[t] = (fd == 0);
                rv[t] = 1;
            end
            if (all_rcvd && !fc_init) phase = 2;
        end else begin
            if (fc_init) begin
                model_reset();
                phase = 1;
            end else begin
                g = rq && r < 3 && !m_grant;
                if (g) g = (ih[r] || fits(lh[r], ch[r], 1, MH)) &&
                           (rd == 0 || id[r] || fits(ld[r], cd[r], int'(rd), MD));
                if (fv && t < 3) begin
                    if (!ih[t]) lh[t] = int'(fh);
                    if (!id[t]) ld[t] = int'(fd);
                end
                if (g) begin
                    ch[r] = (ch[r] + 1) % MH;
                    if (!id[r]) cd[r] = (cd[r] + int'(rd)) % MD;
                end
                m_grant = g;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("grant", 64'(grant), 64'(m_grant));
        chk("init_done", 64'(init_done), 64'(phase == 2));
        chk("hdr_limit", 64'(hlim_bus), 64'({HW'(lh[0]), HW'(lh[1]), HW'(lh[2])}));
        chk("data_limit", 64'(dlim_bus), 64'({DW'(ld[0]), DW'(ld[1]), DW'(ld[2])}));
        chk("hdr_consumed", 64'(hcon_bus), 64'({HW'(ch[0]), HW'(ch[1]), HW'(ch[2])}));
        chk("data_consumed", 64'(dcon_bus), 64'({DW'(cd[0]), DW'(cd[1]), DW'(cd[2])}));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic fc(input int t, input int h, input int d);
        fv = 1; ft = 2'(t); fh = HW'(h); fd = DW'(d);
        cyc();
        fv = 0;
    endtask

    // Raises a request and holds it until a grant or the cycle budget runs out
    task automatic req_wait(input int t, input int d, input int max, output bit got);
        rq = 1; rt = 2'(t); rd = DW'(d);
        got = 0;
        for (int i = 0; i < max; i++) begin
            cyc();
            if (grant) begin got = 1; break; end
        end
    endtask

    task automatic grant_one(input string tag, input int t, input int d);
        bit got;
        req_wait(t, d, 3, got);
        chk(tag, 64'(got), 64'd1);
        rq = 0;
        cyc();
    endtask

    initial begin
        bit got;
        int ngr;
        rst_n = 0; fc_init = 0; fv = 0; ft = 0; fh = 0; fd = 0;
        rq = 0; rt = 0; rd = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1;

        // InitFC sequence
        fc_init = 1; cyc();
        fc(0, 8, 64); fc(1, 4, 0); fc(2, 0, 0);
        fc_init = 0; cyc(); cyc();
        chk("init_done_up", 64'(init_done), 64'd1);
        chk("init_hdr_bus", 64'(hlim_bus), 64'h080400);
        chk("init_data_bus", 64'(dlim_bus), 64'h040000000);

        // Four posted TLPs of 16 data credits, each granted after one edge
        for (int i = 0; i < 4; i++) begin
            req_wait(0, 16, 1, got);
            chk("p16_grant", 64'(got), 64'd1);
            rq = 0; cyc();
        end
        chk("p_data_cons64", 64'(dcon_bus[35:24]), 64'd64);
        req_wait(0, 1, 4, got);
        chk("p_data_stall", 64'(got), 64'd0);
        fc(0, 9, 80);
        req_wait(0, 1, 3, got);
        chk("p_release", 64'(got), 64'd1);
        rq = 0; cyc();

        // NP: infinite data, header limit 4
        ngr = 0;
        for (int i = 0; i < 5; i++) begin
            req_wait(1, 1000, 3, got);
            if (got) ngr++;
            rq = 0; cyc();
        end
        chk("np_grants", 64'(ngr), 64'd4);
        chk("np_data_cons", 64'(dcon_bus[23:12]), 64'd0);

        // Same-edge update and request: old limit decides
        fc(0, ch[0], ld[0]);
        req_wait(0, 0, 2, got);
        chk("same_edge_stall", 64'(got), 64'd0);
        fv = 1; ft = 2'd0; fh = HW'(ch[0] + 1); fd = DW'(ld[0]);
        cyc();
        chk("same_edge_nogrant", 64'(grant), 64'd0);
        fv = 0;
        cyc();
        chk("same_edge_grant", 64'(grant), 64'd1);
        rq = 0; cyc();

        // Re-init from ACTIVE clears everything
        fc_init = 1; cyc();
        chk("reinit_cleared", 64'(hcon_bus), 64'd0);
        chk("reinit_done_low", 64'(init_done), 64'd0);
        fc(0, 1, 0); fc(1, 1, 1); fc(2, 1, 1);
        fc_init = 0; cyc(); cyc();

        // Walk P header consumed up to FE, then wrap through 00
        for (int i = 0; i < 300; i++) begin
            grant_one("walk_grant", 0, 0);
            if (ch[0] == 254) break;
            fc(0, (ch[0] + 1) % MH, 0);
        end
        chk("wrap_pre_cons", 64'(hcon_bus[23:16]), 64'hFE);
        chk("wrap_pre_lim", 64'(hlim_bus[23:16]), 64'hFE);
        req_wait(0, 0, 2, got);
        chk("wrap_stall_fe", 64'(got), 64'd0);
        rq = 0;
        fc(0, 2, 0);
        for (int i = 0; i < 4; i++) grant_one("wrap_grant", 0, 0);
        chk("wrap_cons02", 64'(hcon_bus[23:16]), 64'h02);
        req_wait(0, 0, 3, got);
        chk("wrap_stall_02", 64'(got), 64'd0);
        rq = 0;

        // Randomized traffic against the model
        fc_init = 1; cyc();
        fc(0, $urandom_range(0, 30), $urandom_range(0, 200));
        fc(1, $urandom_range(1, 30), $urandom_range(0, 200));
        fc(2, $urandom_range(1, 30), $urandom_range(1, 200));
        fc_init = 0; cyc(); cyc();
        for (int i = 0; i < 800; i++) begin
            if (!rq || grant) begin
                rq = ($urandom % 3) != 0;
                rt = 2'($urandom % 4);
                rd = ($urandom % 4 == 0) ? '0 : DW'($urandom % 40);
            end
            fv = ($urandom % 4) == 0;
            ft = 2'($urandom % 4);
            if (ft != 2'd3) begin
                fh = HW'((ch[ft] + $urandom % 10) % MH);
                fd = DW'((cd[ft] + $urandom % 120) % MD);
            end else begin
                fh = HW'($urandom); fd = DW'($urandom);
            end
            cyc();
        end
        fv = 0;

        // Asynchronous reset while a grant is showing
        rq = 0; cyc();
        req_wait(0, 0, 20, got);
        if (!got) begin
            fc(0, (ch[0] + 1) % MH, 0);
            req_wait(0, 0, 3, got);
        end
        chk("pre_reset_grant", 64'(got), 64'd1);
        #1 rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("reset_grant_low", 64'(grant), 64'd0);
        rq = 0;
        @(negedge clk) rst_n = 1;
        cyc();
        fc_init = 1; cyc();
        fc_init = 0; cyc();
        chk("idle_after_reset", 64'(init_done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
